// File: rtl/pool_vector_if.sv
// Handshake bundle between the pooling unit and its neighbours.
// Carries upstream samples, window configuration, restart and the result stream.
// master drives samples/config and receives results; slave is the pooling unit.
interface pool_vector_if #(
   parameter int NUM_WIDTH = 16,
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
);
   logic                          restart;
   logic                          cfg_mode;
   logic [CNT_WIDTH-1:0]          cfg_size;
   logic [4:0]                    cfg_shift;
   logic [CHANNELS*NUM_WIDTH-1:0] up_data;
   logic                          up_valid;
   logic [CHANNELS*NUM_WIDTH-1:0] dn_data;
   logic                          dn_valid;

   modport master (
      output restart, cfg_mode, cfg_size, cfg_shift, up_data, up_valid,
      input  dn_data, dn_valid
   );

   modport slave (
      input  restart, cfg_mode, cfg_size, cfg_shift, up_data, up_valid,
      output dn_data, dn_valid
   );
endinterface

// File: rtl/pool_vector.sv
// Per-channel max / shifted-sum-average pooling over a programmable sample window.
// Latency: fixed 3 cycles from the window's last valid sample to the dn_valid pulse.
// Backpressure: none; every valid sample is consumed, results are one-cycle pulses.
// Ports: clk, rst (sync, active high); bus (slave) carries restart, cfg_*,
// up_data/up_valid in and dn_data/dn_valid out.
module pool_vector #(
   parameter int NUM_WIDTH = 16,
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   pool_vector_if.slave bus
);
   localparam int AW = NUM_WIDTH + CNT_WIDTH;
   localparam int DW = CHANNELS * NUM_WIDTH;
   localparam logic signed [AW-1:0] SAT_MAX = {{(CNT_WIDTH+1){1'b0}}, {(NUM_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(CNT_WIDTH+1){1'b1}}, {(NUM_WIDTH-1){1'b0}}};

   // ---------------- stage 1: input register ----------------
   logic                 s1_vld, s1_restart, s1_mode;
   logic [CNT_WIDTH-1:0] s1_size;
   logic [4:0]           s1_shift;
   logic [DW-1:0]        s1_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld     <= 1'b0;
         s1_restart <= 1'b0;
         s1_mode    <= 1'b0;
         s1_size    <= '0;
         s1_shift   <= '0;
         s1_data    <= '0;
      end else begin
         s1_vld     <= bus.up_valid;
         s1_restart <= bus.restart;
         s1_mode    <= bus.cfg_mode;
         s1_size    <= bus.cfg_size;
         s1_shift   <= bus.cfg_shift;
         s1_data    <= bus.up_valid ? bus.up_data : '0;
      end
   end

   // ---------------- stage 2: accumulate / compare, count ----------------
   logic [CNT_WIDTH-1:0] cnt, win_size;
   logic                 win_mode;
   logic [4:0]           win_shift;
   logic                 s2_done;
   logic signed [AW-1:0] acc     [CHANNELS];
   logic signed [AW-1:0] acc_nxt [CHANNELS];
   logic signed [AW-1:0] samp    [CHANNELS];

   logic                 first, done, cur_mode;
   logic [CNT_WIDTH-1:0] cur_size, eff_size, cnt_inc;

   // A valid sample opens a window when the counter is idle or when it
   // arrives together with restart; it then uses its own cycle's config.
   always_comb begin
      first    = s1_vld && ((cnt == '0) || s1_restart);
      cur_mode = first ? s1_mode : win_mode;
      cur_size = first ? s1_size : win_size;
      eff_size = (cur_size == '0) ? CNT_WIDTH'(1) : cur_size;
      cnt_inc  = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
      done     = s1_vld && (cnt_inc == eff_size);
   end

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         samp[k] = {{CNT_WIDTH{s1_data[k*NUM_WIDTH + NUM_WIDTH - 1]}},
                    s1_data[k*NUM_WIDTH +: NUM_WIDTH]};
         acc_nxt[k] = acc[k];
         if (first)
            acc_nxt[k] = samp[k];
         else if (cur_mode)
            acc_nxt[k] = acc[k] + samp[k];
         else if (samp[k] > acc[k])
            acc_nxt[k] = samp[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         s2_done <= 1'b0;
      end else begin
         s2_done <= done;
         if (s1_vld)
            cnt <= done ? '0 : cnt_inc;
         else if (s1_restart)
            cnt <= '0;
      end
   end

   // Accumulators and latched window config need no reset: the first sample
   // of every window overwrites them before they are ever consumed.
   always_ff @(posedge clk) begin
      if (s1_vld) begin
         for (int k = 0; k < CHANNELS; k++)
            acc[k] <= acc_nxt[k];
      end
      if (first) begin
         win_mode  <= s1_mode;
         win_size  <= s1_size;
         win_shift <= s1_shift;
      end
   end

   // ---------------- stage 3: format and register ----------------
   // win_* still describe the finished window here: a following window can
   // only relatch them on the same edge that captures this result.
   logic signed [AW-1:0] shifted [CHANNELS];
   logic [DW-1:0]        res;
   logic [DW-1:0]        dn_data_r;
   logic                 dn_valid_r;

   always_comb begin
      res = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         shifted[k] = acc[k] >>> win_shift;
         if (!win_mode)
            res[k*NUM_WIDTH +: NUM_WIDTH] = acc[k][NUM_WIDTH-1:0];
         else if (shifted[k] > SAT_MAX)
            res[k*NUM_WIDTH +: NUM_WIDTH] = SAT_MAX[NUM_WIDTH-1:0];
         else if (shifted[k] < SAT_MIN)
            res[k*NUM_WIDTH +: NUM_WIDTH] = SAT_MIN[NUM_WIDTH-1:0];
         else
            res[k*NUM_WIDTH +: NUM_WIDTH] = shifted[k][NUM_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid_r <= 1'b0;
         dn_data_r  <= '0;
      end else begin
         dn_valid_r <= s2_done;
         if (s2_done)
            dn_data_r <= res;
      end
   end

   assign bus.dn_data  = dn_data_r;
   assign bus.dn_valid = dn_valid_r;
endmodule

// File: tb/tb_pool_vector.sv
// Randomized and directed bench for pool_vector against a window-level model.
// The model collects each window's samples and computes max / floor-average directly.
module tb_pool_vector;
   localparam int NW = 16;
   localparam int CH = 4;
   localparam int CW = 8;
   localparam int DW = NW * CH;

   typedef struct {
      int            due;
      logic [DW-1:0] dat;
   } exp_t;

   logic clk;
   logic rst;
   pool_vector_if #(.NUM_WIDTH(NW), .CHANNELS(CH), .CNT_WIDTH(CW)) pif ();

   pool_vector #(.NUM_WIDTH(NW), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (pif.slave)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            n_dn = 0;
   int            last_dn_cyc = 0;
   logic [DW-1:0] last_obs = '0;
   logic [DW-1:0] last_exp = '0;
   bit            clear_pending = 0;
   exp_t          exp_q[$];
   logic [DW-1:0] win_q[$];
   logic [DW-1:0] obs_q[$];
   logic [DW-1:0] ref_q[$];
   logic [DW-1:0] stream[20];
   bit            win_mode;
   int            win_size;
   int            win_shift;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [DW-1:0] vec(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Result of the collected window, straight from the arithmetic definition.
   function automatic logic [DW-1:0] window_result();
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < CH; k++) begin
         longint best, sum, q, d;
         logic signed [NW-1:0] v;
         best = 0;
         sum  = 0;
         for (int i = 0; i < win_q.size(); i++) begin
            v = win_q[i][k*NW +: NW];
            if (i == 0 || longint'(v) > best) best = v;
            sum += v;
         end
         if (win_mode) begin
            d = longint'(1) << win_shift;
            q = sum / d;
            if (sum < 0 && q * d != sum) q--;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            r[k*NW +: NW] = 16'(q);
         end else begin
            r[k*NW +: NW] = 16'(best);
         end
      end
      return r;
   endfunction

   task automatic model_step();
      if (rst) begin
         win_q.delete();
         for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].due > cyc) exp_q.delete(i);
         clear_pending = 1;
         return;
      end
      if (pif.restart) win_q.delete();
      if (pif.up_valid) begin
         if (win_q.size() == 0) begin
            win_mode  = pif.cfg_mode;
            win_size  = (pif.cfg_size == 0) ? 1 : int'(pif.cfg_size);
            win_shift = int'(pif.cfg_shift);
         end
         win_q.push_back(pif.up_data);
         if (win_q.size() == win_size) begin
            exp_q.push_back('{due: cyc + 3, dat: window_result()});
            win_q.delete();
         end
      end
   endtask

   task automatic monitor();
      bit            exp_v;
      logic [DW-1:0] exp_d;
      if (clear_pending) begin
         last_exp      = '0;
         clear_pending = 0;
      end
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (exp_v) begin
         exp_d    = exp_q[0].dat;
         void'(exp_q.pop_front());
         last_exp = exp_d;
      end else begin
         exp_d = last_exp;
      end
      check("dn_valid", DW'(pif.dn_valid), DW'(exp_v));
      check("dn_data", pif.dn_data, exp_d);
      if (pif.dn_valid === 1'b1) begin
         n_dn++;
         last_dn_cyc = cyc;
         last_obs    = pif.dn_data;
         obs_q.push_back(pif.dn_data);
      end
   endtask

   // One clock: check outputs and step the model mid-cycle, then advance.
   task automatic tick();
      @(negedge clk);
      monitor();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive(input bit v, input bit r, input logic [DW-1:0] d);
      pif.up_valid = v;
      pif.restart  = r;
      pif.up_data  = d;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, '0);
   endtask

   task automatic set_cfg(input bit m, input int s, input int sh);
      pif.cfg_mode  = m;
      pif.cfg_size  = CW'(s);
      pif.cfg_shift = 5'(sh);
   endtask

   initial begin
      int n0, samp_cyc;
      rst          = 1'b1;
      pif.up_valid = 1'b0;
      pif.restart  = 1'b0;
      pif.up_data  = '0;
      set_cfg(0, 4, 0);
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      check("reset_vld", DW'(pif.dn_valid), '0);
      check("reset_dat", pif.dn_data, '0);
      idle(2);

      // Max mode, size 4
      set_cfg(0, 4, 0);
      n0 = n_dn;
      drive(1, 0, vec(3, -5, 0, 0));
      drive(1, 0, vec(-7, -2, 0, 0));
      drive(1, 0, vec(12, -9, 0, 0));
      samp_cyc = cyc;
      drive(1, 0, vec(5, -3, 0, 0));
      idle(5);
      check("max_res", last_obs, vec(12, -2, 0, 0));
      check("max_cnt", DW'(n_dn - n0), DW'(1));
      check("max_lat", DW'(last_dn_cyc - samp_cyc), DW'(3));

      // Average mode, size 4, shift 2
      set_cfg(1, 4, 2);
      n0 = n_dn;
      drive(1, 0, vec(10, -10, 0, 0));
      drive(1, 0, vec(20, -20, 0, 0));
      drive(1, 0, vec(30, -30, 0, 0));
      drive(1, 0, vec(41, -41, 0, 0));
      idle(5);
      check("avg_res", last_obs, vec(25, -26, 0, 0));
      check("avg_cnt", DW'(n_dn - n0), DW'(1));

      // Saturation
      set_cfg(1, 4, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, vec(32767, -32768, 0, 0));
      idle(5);
      check("sat_res", last_obs, vec(32767, -32768, 0, 0));

      // Restart with the 3rd sample; mode change mid-window ignored
      set_cfg(0, 4, 0);
      n0 = n_dn;
      drive(1, 0, vec(100, 50, 0, 0));
      drive(1, 0, vec(200, 60, 0, 0));
      drive(1, 1, vec(5, -1, 0, 0));
      pif.cfg_mode = 1'b1;
      drive(1, 0, vec(7, -4, 0, 0));
      drive(1, 0, vec(-3, -8, 0, 0));
      drive(1, 0, vec(6, -2, 0, 0));
      idle(5);
      check("rst_win_res", last_obs, vec(7, -1, 0, 0));
      check("rst_win_cnt", DW'(n_dn - n0), DW'(1));

      // Reset mid-window
      set_cfg(0, 4, 0);
      n0 = n_dn;
      for (int i = 0; i < 3; i++) drive(1, 0, vec(1000, 1000, 1000, 1000));
      rst = 1'b1;
      drive(0, 0, '0);
      rst = 1'b0;
      check("midrst_vld", DW'(pif.dn_valid), '0);
      check("midrst_dat", pif.dn_data, '0);
      drive(1, 0, vec(1, -5, 0, 9));
      drive(1, 0, vec(4, -6, 0, 8));
      drive(1, 0, vec(2, -7, 0, 7));
      drive(1, 0, vec(3, -8, 0, 6));
      idle(5);
      check("midrst_res", last_obs, vec(4, -5, 0, 9));
      check("midrst_cnt", DW'(n_dn - n0), DW'(1));

      // Streaming: size 1 and size 0 with continuous valid
      for (int i = 0; i < 20; i++)
         stream[i] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      for (int s = 0; s < 2; s++) begin
         set_cfg(s[0], 1 - s, 0);
         n0 = n_dn;
         for (int i = 0; i < 20; i++) drive(1, 0, stream[i]);
         idle(4);
         check("stream_cnt", DW'(n_dn - n0), DW'(20));
         check("stream_last", last_obs, stream[19]);
      end

      // Gap-free vs bubbled stream must give identical results
      set_cfg(1, 2, 1);
      obs_q.delete();
      for (int i = 0; i < 20; i++) drive(1, 0, stream[i]);
      idle(5);
      ref_q = obs_q;
      obs_q.delete();
      for (int i = 0; i < 20; i++) begin
         while ($urandom_range(0, 2) == 0) drive(0, 0, DW'($urandom));
         drive(1, 0, stream[i]);
      end
      idle(5);
      check("bubble_cnt", DW'(obs_q.size()), DW'(ref_q.size()));
      for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
         check("bubble_res", obs_q[i], ref_q[i]);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0)
            set_cfg($urandom_range(0, 1) == 1, $urandom_range(0, 6), $urandom_range(0, 5));
         rst = ($urandom_range(0, 99) < 2);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
               {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)});
      end
      rst = 1'b0;
      idle(6);
      check("drain", DW'(exp_q.size()), '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pool_vector.md
Name: pool_vector

Overview:
- Multi-channel, window-counting pooling unit for the CNN datapath.
- Reduces a stream of CHANNELS-wide sample vectors over a programmable number of samples, per channel in parallel.
- Modes: signed maximum or shifted-sum average, selected per window.
- Emits one dn_valid-qualified result vector per completed window. Sits between the convolution/activation output and the result buffer.

Parameters:
- NUM_WIDTH, 16: width of one signed channel sample.
- CHANNELS, 4: number of parallel channels packed in up_data/dn_data.
- CNT_WIDTH, 8: width of the window-size counter; the maximum window is 2^CNT_WIDTH-1 samples.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- restart, input, 1: aborts the partial window; the next valid sample starts a new window.
- cfg_mode, input, 1: 0 = max, 1 = average.
- cfg_size, input, CNT_WIDTH: samples per window; 0 is treated as 1.
- cfg_shift, input, 5: arithmetic right shift applied to the sum in average mode.
- up_data, input, CHANNELS*NUM_WIDTH: sample vector; channel k occupies bits [k*NUM_WIDTH +: NUM_WIDTH].
- up_valid, input, 1: up_data is valid this cycle. There is no backpressure.
- dn_data, output, CHANNELS*NUM_WIDTH: result vector, same packing as up_data.
- dn_valid, output, 1: one-cycle pulse; dn_data holds a new window result.

Behaviour:
- Reset: one clock with rst high sets dn_valid=0, dn_data=0, sample counter=0 and all pipeline valid flags=0.
  - rst mid-window discards the partial window and any in-flight results; no dn_valid is produced for them.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Pipeline: 3 stages with fixed latency.
  - If the last sample of a window has up_valid=1 in cycle n, dn_valid=1 in cycle n+3 only.
  - Stage 1 registers up_data, up_valid and restart together. Data is zeroed when not valid.
  - Stage 2 performs the per-channel accumulate/compare and counting.
  - Stage 3 performs output formatting and registering.
- Window counting:
  - Only valid samples count; gaps in up_valid are allowed and do not affect results.
  - The first valid sample of a window loads the accumulator directly (no seeding from 0) and latches cfg_mode, cfg_size and cfg_shift for the whole window.
  - When the valid-sample count reaches the latched size, the window completes and the counter returns to 0.
  - The next valid sample, including one in the immediately following cycle, starts a new window with no bubble.
- Max mode: per channel, signed compare; the accumulator is replaced when new > held. Ties keep the held value.
- Average mode:
  - Per channel, the sample is sign-extended to NUM_WIDTH+CNT_WIDTH bits and added. This width cannot overflow.
  - Result = sum >>> latched shift, which is floor division for negative sums.
  - The result is then saturated to [-2^(NUM_WIDTH-1), 2^(NUM_WIDTH-1)-1].
- Output: dn_data updates only on completion and holds its value between windows. dn_valid is never high for two windows in the same cycle.
- Restart:
  - restart in cycle n affects samples presented in cycles >= n.
  - A sample with up_valid=1 in the same cycle as restart becomes the first sample of the new window.
  - Windows completed by samples before cycle n still produce their dn_valid.
  - restart with no valid samples simply clears the counter.
- cfg_* changes mid-window are ignored until the next window starts.

Test Plan:
- Max mode, size=4, ch0 = 3, -7, 12, 5 and ch1 = -5, -2, -9, -3 on consecutive cycles -> ch0 = 12 and ch1 = -2. dn_valid is high exactly in the cycle 3 after the 4th sample, for 1 cycle.
- Average mode, size=4, shift=2, ch0 = 10, 20, 30, 41 and ch1 = -10, -20, -30, -41 -> ch0 = 25 and ch1 = -26.
- Saturation: average mode, size=4, shift=0; ch0 all 32767 -> 32767; ch1 all -32768 -> -32768.
- Restart: size=4; 2 valid samples, then restart together with the 3rd sample, then 3 more samples.
  - Result reflects only the last 4 samples; exactly one dn_valid.
  - Changing cfg_mode after the 3rd sample has no effect.
- Streaming: size=1 (and size=0) with continuous up_valid -> dn_valid every cycle and dn_data = up_data delayed 3. Repeating with random up_valid bubbles gives results identical to the gap-free stream.
- Reset mid-window: size=4, 3 samples, then rst for 1 cycle, then 4 samples.
  - dn_data=0 and dn_valid=0 after rst.
  - A single dn_valid occurs for the post-reset window, with the correct value.
